imem_dmem_arbiter: RTL

Shares one single-port, synchronous-read unified memory between the instruction-fetch port (read-only) and the data port (read/write) of the multi-cycle core. A round-robin FSM serialises requests and drives registered memory controls. It returns read data with a one-cycle ack pulse. It also keeps saturating per-port grant counters that feed the LED/SSD debug mux.

---
 rtl/imem_dmem_arbiter_if.sv | 43 ++++
 rtl/imem_dmem_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side fetch/data ports, memory-side controls and debug counters of the arbiter.
interface imem_dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [CNT_W-1:0]  f_grants;
    logic [CNT_W-1:0]  d_grants;

    // Arbiter view
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata, f_grants, d_grants
    );

    // Requester / memory / debug view
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata, f_grants, d_grants
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between fetch and data ports.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_dmem_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              wr_q,        wr_d;
    logic              last_q,      last_d;
    logic              busy_q,      busy_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] f_rdata_q,   f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              f_ack_q,     f_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [CNT_W-1:0]  f_cnt_q,     f_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q,     d_cnt_d;
    logic              pick_data;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        last_d      = last_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        f_cnt_d     = f_cnt_q;
        d_cnt_d     = d_cnt_q;
        // Data wins when alone, or when contested and fetch had the last grant
        pick_data   = bus.d_req && (!bus.f_req || (last_q == OWN_F));

        case (state_q)
            S_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    owner_d  = pick_data ? OWN_D : OWN_F;
                    last_d   = pick_data ? OWN_D : OWN_F;
                    wr_d     = pick_data && bus.d_we;
                    mem_en_d = 1'b1;
                    mem_we_d = pick_data && bus.d_we;
                    state_d  = S_ACCESS;
                    if (pick_data) begin
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
                    end else begin
                        mem_addr_d  = bus.f_addr;
                        mem_wdata_d = '0;
                        if (f_cnt_q != '1) f_cnt_d = f_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACCESS: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (owner_q == OWN_F) begin
                    f_rdata_d = bus.mem_rdata;
                    f_ack_d   = 1'b1;
                end else begin
                    if (!wr_q) d_rdata_d = bus.mem_rdata;
                    d_ack_d = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_F;
            wr_q        <= 1'b0;
            last_q      <= OWN_D;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_cnt_q     <= '0;
            d_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_cnt_q     <= f_cnt_d;
            d_cnt_q     <= d_cnt_d;
        end
    end

    assign bus.f_ack     = f_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.f_grants  = f_cnt_q;
    assign bus.d_grants  = d_cnt_q;
endmodule
